// File: rtl/shot_pkg.sv
// Shared types and constants for the shot path (fire controller and shot mover).
package shot_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } shot_state_t;

  localparam logic [2:0] DIR_RIGHT    = 3'b001;
  localparam logic [2:0] DIR_STRAIGHT = 3'b010;
  localparam logic [2:0] DIR_LEFT     = 3'b100;

  // Steering keys to one-hot direction; both or neither means straight.
  function automatic logic [2:0] decode_dir(input logic left, input logic right);
    logic [2:0] dir;
    case ({left, right})
      2'b10:   dir = DIR_LEFT;
      2'b01:   dir = DIR_RIGHT;
      default: dir = DIR_STRAIGHT;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter stepped by frame ticks; saturates at zero.
// zeroNext flags the cycle in which a tick takes the count from 1 to 0.
module frame_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             tick,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             zeroNext
);

  logic             dec_s;
  logic [WIDTH-1:0] count_r;

  // A decrement happens on an unheld tick while nonzero; a load overrides it.
  always_comb begin
    dec_s    = tick & ~hold & (count_r != '0);
    zeroNext = ~load & dec_s & (count_r == WIDTH'(1));
  end

  // Count register: load wins over decrement.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= loadValue;
    end else if (dec_s) begin
      count_r <= count_r - WIDTH'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/shot_fire_controller.sv
// Turns fire/steer keys into a one-cycle shot trigger with direction,
// enforcing semi-automatic fire, frame cooldown and a power-up window.
module shot_fire_controller
  import shot_pkg::*;
#(
  parameter int COOLDOWN_FRAMES    = 8,
  parameter int PU_COOLDOWN_FRAMES = 4,
  parameter int PU_DURATION_FRAMES = 300
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fireKey,
  input  logic       leftKey,
  input  logic       rightKey,
  input  logic       shotEnable,
  input  logic       powerUpPickup,
  input  logic       pause,
  output logic       triggerShot,
  output logic [2:0] shotDirection,
  output logic       poweredUp,
  output logic       cooldownActive,
  output logic [7:0] shotCount
);

  shot_state_t state_r;
  logic        fire_key_d_r;
  logic        buffered_r;
  logic        fire_rise_s;
  logic        cd_load_s;
  logic [7:0]  cd_value_s;
  logic [7:0]  cd_count_s;
  logic        cd_zero_s;
  logic [9:0]  pu_count_s;
  logic        pu_unused_zero_s;

  // Edge detect and cooldown reload value, chosen from the registered power-up flag.
  always_comb begin
    fire_rise_s = fireKey & ~fire_key_d_r;
    cd_load_s   = (state_r == FIRE);
    cd_value_s  = 8'(COOLDOWN_FRAMES);
    if (poweredUp) begin
      cd_value_s = 8'(PU_COOLDOWN_FRAMES);
    end else begin
      cd_value_s = 8'(COOLDOWN_FRAMES);
    end
  end

  frame_down_counter #(.WIDTH(8)) u_cooldown (
    .clk       (clk),
    .resetN    (resetN),
    .load      (cd_load_s),
    .loadValue (cd_value_s),
    .tick      (startOfFrame),
    .hold      (pause),
    .count     (cd_count_s),
    .zeroNext  (cd_zero_s)
  );

  frame_down_counter #(.WIDTH(10)) u_powerup (
    .clk       (clk),
    .resetN    (resetN),
    .load      (powerUpPickup),
    .loadValue (10'(PU_DURATION_FRAMES)),
    .tick      (startOfFrame),
    .hold      (pause),
    .count     (pu_count_s),
    .zeroNext  (pu_unused_zero_s)
  );

  // Fire FSM with registered outputs; power-up flag lags the timer by one cycle.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r        <= IDLE;
      fire_key_d_r   <= 1'b0;
      buffered_r     <= 1'b0;
      triggerShot    <= 1'b0;
      shotDirection  <= DIR_STRAIGHT;
      poweredUp      <= 1'b0;
      cooldownActive <= 1'b0;
      shotCount      <= 8'd0;
    end else begin
      fire_key_d_r <= fireKey;
      poweredUp    <= (pu_count_s != 10'd0);
      triggerShot  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fire_rise_s) begin
            state_r <= PENDING;
          end
        end
        PENDING: begin
          if (!fireKey) begin
            state_r <= IDLE;
          end else if (shotEnable && !pause) begin
            state_r       <= FIRE;
            triggerShot   <= 1'b1;
            shotDirection <= decode_dir(leftKey, rightKey);
            shotCount     <= shotCount + 8'd1;
          end
        end
        FIRE: begin
          state_r        <= COOLDOWN;
          cooldownActive <= 1'b1;
        end
        COOLDOWN: begin
          if (cd_zero_s) begin
            state_r        <= (buffered_r && fireKey) ? PENDING : IDLE;
            buffered_r     <= 1'b0;
            cooldownActive <= 1'b0;
          end else if (cd_count_s == 8'd0) begin
            // Counter cannot be zero here in normal operation; recover to IDLE.
            state_r        <= IDLE;
            buffered_r     <= 1'b0;
            cooldownActive <= 1'b0;
          end else if (fire_rise_s) begin
            buffered_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          buffered_r     <= 1'b0;
          cooldownActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_fire_controller.sv
// Scoreboard bench for shot_fire_controller: each expected shot (cycle,
// direction, count) is queued when its stimulus is driven and checked when
// triggerShot appears.
module tb_shot_fire_controller;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, fireKey, leftKey, rightKey;
  logic       shotEnable, powerUpPickup, pause;
  logic       triggerShot, poweredUp, cooldownActive;
  logic [2:0] shotDirection;
  logic [7:0] shotCount;

  typedef struct {
    int cyc;
    int dir;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   live_frames = 0;
  int   base;

  shot_fire_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .fireKey        (fireKey),
    .leftKey        (leftKey),
    .rightKey       (rightKey),
    .shotEnable     (shotEnable),
    .powerUpPickup  (powerUpPickup),
    .pause          (pause),
    .triggerShot    (triggerShot),
    .shotDirection  (shotDirection),
    .poweredUp      (poweredUp),
    .cooldownActive (cooldownActive),
    .shotCount      (shotCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
    step();
    step();
    if (!pause) live_frames++;
  endtask

  task automatic frame_with_pickup();
    startOfFrame  = 1'b1;
    powerUpPickup = 1'b1;
    step();
    startOfFrame  = 1'b0;
    powerUpPickup = 1'b0;
    step();
    step();
    step();
    live_frames++;
  endtask

  task automatic push_shot(input int at_cyc, input int dir, input int cnt);
    exp_t e;
    e.cyc = at_cyc;
    e.dir = dir;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Shot monitor: every trigger pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (triggerShot) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_shot", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("shot_cycle", cyc, e.cyc);
        chk("shot_dir", int'(shotDirection), e.dir);
        chk("shot_count", int'(shotCount), e.cnt);
      end
    end
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; fireKey = 1'b0; leftKey = 1'b0;
    rightKey = 1'b0; shotEnable = 1'b0; powerUpPickup = 1'b0; pause = 1'b0;
    repeat (3) step();
    chk("rst_trigger", int'(triggerShot), 0);
    chk("rst_dir", int'(shotDirection), 2);
    chk("rst_powered", int'(poweredUp), 0);
    chk("rst_cooldown", int'(cooldownActive), 0);
    chk("rst_count", int'(shotCount), 0);
    resetN = 1'b1;
    step();

    // Shot 1: left, latency 2 from the rise.
    leftKey = 1'b1; shotEnable = 1'b1; fireKey = 1'b1;
    push_shot(cyc + 2, 4, 1);
    repeat (3) step();
    chk("cd_enter", int'(cooldownActive), 1);

    // Held key through cooldown: no refire.
    repeat (7) frame();
    chk("cd_after7", int'(cooldownActive), 1);
    frame();
    chk("cd_after8", int'(cooldownActive), 0);
    repeat (3) frame();

    // Release and re-press: shot 2, right.
    fireKey = 1'b0; step();
    leftKey = 1'b0; rightKey = 1'b1; fireKey = 1'b1;
    push_shot(cyc + 2, 1, 2);
    repeat (3) step();

    // Buffered press during cooldown fires once after exit.
    repeat (3) frame();
    fireKey = 1'b0; step();
    leftKey = 1'b1; rightKey = 1'b1; fireKey = 1'b1;
    step(); step();
    repeat (4) frame();
    push_shot(cyc + 2, 2, 3);
    frame();
    repeat (3) step();
    fireKey = 1'b0;
    repeat (8) frame();
    chk("cd_done_s3", int'(cooldownActive), 0);

    // shotEnable low while held, then raised.
    shotEnable = 1'b0; leftKey = 1'b0; rightKey = 1'b1; fireKey = 1'b1;
    repeat (5) frame();
    shotEnable = 1'b1;
    push_shot(cyc + 1, 1, 4);
    repeat (3) step();
    fireKey = 1'b0;
    repeat (8) frame();
    // Released before enable: dropped.
    shotEnable = 1'b0; fireKey = 1'b1;
    repeat (5) step();
    fireKey = 1'b0;
    repeat (2) step();
    shotEnable = 1'b1;
    repeat (5) step();

    // Power-up: 4-frame cooldown and 300-frame window.
    powerUpPickup = 1'b1; step(); powerUpPickup = 1'b0;
    base = live_frames;
    step();
    chk("pu_on", int'(poweredUp), 1);
    leftKey = 1'b1; rightKey = 1'b0; fireKey = 1'b1;
    push_shot(cyc + 2, 4, 5);
    repeat (3) step();
    fireKey = 1'b0;
    repeat (3) frame();
    chk("pu_cd_after3", int'(cooldownActive), 1);
    frame();
    chk("pu_cd_after4", int'(cooldownActive), 0);
    while ((live_frames - base) < 299) frame();
    chk("pu_f299", int'(poweredUp), 1);
    frame();
    chk("pu_f300", int'(poweredUp), 0);

    // Re-pickup on frame 150 (same cycle as a tick: load wins) extends to 450.
    powerUpPickup = 1'b1; step(); powerUpPickup = 1'b0;
    repeat (149) frame();
    frame_with_pickup();
    for (int i = 1; i <= 299; i++) begin
      frame();
      if (i == 150) chk("pu_ext_f300", int'(poweredUp), 1);
    end
    chk("pu_ext_f449", int'(poweredUp), 1);
    frame();
    chk("pu_ext_f450", int'(poweredUp), 0);

    // Pause mid-cooldown and mid-power-up freezes both timers.
    powerUpPickup = 1'b1; step(); powerUpPickup = 1'b0;
    step();
    base = live_frames;
    leftKey = 1'b0; rightKey = 1'b1; fireKey = 1'b1;
    push_shot(cyc + 2, 1, 6);
    repeat (3) step();
    fireKey = 1'b0;
    repeat (2) frame();
    pause = 1'b1; step();
    repeat (20) frame();
    chk("pause_cd_frozen", int'(cooldownActive), 1);
    chk("pause_pu_frozen", int'(poweredUp), 1);
    pause = 1'b0;
    frame();
    chk("pause_cd_resume3", int'(cooldownActive), 1);
    frame();
    chk("pause_cd_resume4", int'(cooldownActive), 0);
    while ((live_frames - base) < 299) frame();
    chk("pause_pu_f299", int'(poweredUp), 1);
    frame();
    chk("pause_pu_f300", int'(poweredUp), 0);

    // Pause while pending: fires on first unpaused cycle.
    pause = 1'b1; leftKey = 1'b1; rightKey = 1'b0; fireKey = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    push_shot(cyc + 1, 4, 7);
    repeat (3) step();
    fireKey = 1'b0;
    repeat (8) frame();

    // Reset while pending: shot lost, registers back to reset values.
    leftKey = 1'b0; rightKey = 1'b1; fireKey = 1'b1;
    step();
    resetN = 1'b0;
    step();
    chk("mid_rst_dir", int'(shotDirection), 2);
    chk("mid_rst_count", int'(shotCount), 0);
    chk("mid_rst_trigger", int'(triggerShot), 0);
    chk("mid_rst_cooldown", int'(cooldownActive), 0);
    resetN = 1'b1; fireKey = 1'b0;
    step(); step();
    fireKey = 1'b1;
    push_shot(cyc + 2, 1, 1);
    repeat (3) step();
    fireKey = 1'b0;
    repeat (10) step();

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
